// File: rtl/down_counter_if.sv
// down_counter_if: load/hold controls and count/borrow/busy status of a down_counter.
interface down_counter_if #(parameter int n = 4);
    logic         Start;
    logic [n-1:0] Load_val;
    logic         Hold;
    logic [n-1:0] Q;
    logic         borrow;
    logic         busy;
    modport master (output Start, Load_val, Hold, input Q, borrow, busy);
    modport slave  (input Start, Load_val, Hold, output Q, borrow, busy);
endinterface

// File: rtl/down_counter.sv
// down_counter: loadable modulo-k down-counter with registered one-cycle borrow on wrap.
module down_counter #(
    parameter int n      = 4,
    parameter int k      = 10,
    parameter int RELOAD = 1
) (
    input logic          Clock,
    input logic          Reset,
    down_counter_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [n:0]   k_wide  = (n+1)'(k);
    localparam logic [n-1:0] top_val = n'(k - 1);
    state_t       state, state_nx;
    logic [n-1:0] q_nx, load_q;
    logic         borrow_nx;
    // n+1-bit compare so that k = 2^n never truncates
    assign load_q = ({1'b0, bus.Load_val} >= k_wide || bus.Load_val == '0) ? top_val : bus.Load_val;
    always_comb begin
        state_nx  = state;
        q_nx      = bus.Q;
        borrow_nx = 1'b0;
        if (state == IDLE) begin
            if (bus.Start) begin
                q_nx     = load_q;
                state_nx = RUN;
            end
        end else if (bus.Start) begin
            q_nx = load_q;
        end else if (!bus.Hold) begin
            if (bus.Q != '0) begin
                q_nx = bus.Q - n'(1);
            end else begin
                borrow_nx = 1'b1;
                q_nx      = (RELOAD != 0) ? top_val : '0;
                state_nx  = (RELOAD != 0) ? RUN : IDLE;
            end
        end
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            bus.Q      <= '0;
            bus.borrow <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            state      <= state_nx;
            bus.Q      <= q_nx;
            bus.borrow <= borrow_nx;
            bus.busy   <= (state_nx == RUN);
        end
    end
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: scenario tasks plus randomized run against an arithmetic reference model.
module tb_down_counter;
    logic clk = 0, rst = 0, start = 0, hold = 0;
    logic [3:0] lv = 0;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    down_counter_if #(.n(4)) i0(), i1(), i2();
    down_counter #(.n(4), .k(10), .RELOAD(1)) d0 (.Clock(clk), .Reset(rst), .bus(i0.slave));
    down_counter #(.n(4), .k(10), .RELOAD(0)) d1 (.Clock(clk), .Reset(rst), .bus(i1.slave));
    down_counter #(.n(4), .k(16), .RELOAD(1)) d2 (.Clock(clk), .Reset(rst), .bus(i2.slave));
    assign i0.Start = start; assign i0.Load_val = lv; assign i0.Hold = hold;
    assign i1.Start = start; assign i1.Load_val = lv; assign i1.Hold = hold;
    assign i2.Start = start; assign i2.Load_val = lv; assign i2.Hold = hold;
    logic [3:0] q [3];
    logic       b [3], bz [3];
    assign q[0] = i0.Q; assign b[0] = i0.borrow; assign bz[0] = i0.busy;
    assign q[1] = i1.Q; assign b[1] = i1.borrow; assign bz[1] = i1.busy;
    assign q[2] = i2.Q; assign b[2] = i2.borrow; assign bz[2] = i2.busy;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        start = 0; hold = 0; lv = 0;
        rst = 1; #2; rst = 0;
        tick;
    endtask

    task automatic load(input int v);
        lv = 4'(v); start = 1;
        tick;
        start = 0;
    endtask

    task automatic test_reset;
        do_reset;
        load(7);
        tick; tick; tick;
        checks++; if (q[0] !== 4'd4) begin failures++; $display("FAIL reset_pre_q got=%0d exp=4", q[0]); end
        #2 rst = 1;
        #1;
        checks++; if (q[0] !== 4'd0) begin failures++; $display("FAIL reset_async_q got=%0d exp=0", q[0]); end
        checks++; if (bz[0] !== 1'b0) begin failures++; $display("FAIL reset_async_busy got=%0d exp=0", bz[0]); end
        checks++; if (b[0] !== 1'b0) begin failures++; $display("FAIL reset_async_borrow got=%0d exp=0", b[0]); end
        #1 rst = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (q[0] !== 4'd0 || bz[0] !== 1'b0) begin failures++; $display("FAIL reset_idle q=%0d busy=%0d exp q=0 busy=0", q[0], bz[0]); end
        end
    endtask

    task automatic test_free_run;
        int bt[$];
        do_reset;
        load(3);
        for (int c = 0; c < 30; c++) begin
            int eq = ((3 - c) % 10 + 10) % 10;
            logic eb = (c >= 4) && ((c - 4) % 10 == 0);
            checks++; if (q[0] !== 4'(eq)) begin failures++; $display("FAIL free_q c=%0d got=%0d exp=%0d", c, q[0], eq); end
            checks++; if (b[0] !== eb) begin failures++; $display("FAIL free_borrow c=%0d got=%0d exp=%0d", c, b[0], eb); end
            if (b[0]) bt.push_back(c);
            tick;
        end
        checks++; if (bt.size() != 3) begin failures++; $display("FAIL free_pulses got=%0d exp=3", bt.size()); end
        for (int i = 1; i < bt.size(); i++) begin
            checks++; if (bt[i] - bt[i-1] != 10) begin failures++; $display("FAIL free_spacing got=%0d exp=10", bt[i] - bt[i-1]); end
        end
    endtask

    task automatic test_one_shot;
        do_reset;
        load(2);
        for (int c = 0; c < 10; c++) begin
            int eq = (c < 2) ? 2 - c : 0;
            logic ebz = (c < 3);
            logic eb = (c == 3);
            checks++; if (q[1] !== 4'(eq)) begin failures++; $display("FAIL oneshot_q c=%0d got=%0d exp=%0d", c, q[1], eq); end
            checks++; if (bz[1] !== ebz) begin failures++; $display("FAIL oneshot_busy c=%0d got=%0d exp=%0d", c, bz[1], ebz); end
            checks++; if (b[1] !== eb) begin failures++; $display("FAIL oneshot_borrow c=%0d got=%0d exp=%0d", c, b[1], eb); end
            tick;
        end
    endtask

    task automatic test_clamp;
        do_reset;
        load(12);
        checks++; if (q[0] !== 4'd9) begin failures++; $display("FAIL clamp12_k10 got=%0d exp=9", q[0]); end
        checks++; if (q[2] !== 4'd12) begin failures++; $display("FAIL load12_k16 got=%0d exp=12", q[2]); end
        load(0);
        checks++; if (q[0] !== 4'd9) begin failures++; $display("FAIL zero_k10 got=%0d exp=9", q[0]); end
        checks++; if (q[2] !== 4'd15) begin failures++; $display("FAIL zero_k16 got=%0d exp=15", q[2]); end
        load(15);
        checks++; if (q[2] !== 4'd15) begin failures++; $display("FAIL load15_k16 got=%0d exp=15", q[2]); end
        checks++; if (q[1] !== 4'd9) begin failures++; $display("FAIL clamp15_k10 got=%0d exp=9", q[1]); end
    endtask

    task automatic test_hold;
        int c;
        do_reset;
        load(5);
        tick; tick;
        checks++; if (q[0] !== 4'd3) begin failures++; $display("FAIL hold_pre got=%0d exp=3", q[0]); end
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (q[0] !== 4'd3 || b[0] !== 1'b0) begin failures++; $display("FAIL hold_freeze q=%0d borrow=%0d exp q=3 borrow=0", q[0], b[0]); end
        end
        hold = 0;
        tick;
        checks++; if (q[0] !== 4'd2) begin failures++; $display("FAIL hold_resume got=%0d exp=2", q[0]); end
        c = 7;
        while (!b[0] && c < 30) begin tick; c++; end
        checks++; if (c != 10) begin failures++; $display("FAIL hold_borrow_delay got=%0d exp=10", c); end
    endtask

    task automatic test_simultaneous;
        do_reset;
        load(2);
        tick; tick;
        checks++; if (q[0] !== 4'd0) begin failures++; $display("FAIL simul_zero got=%0d exp=0", q[0]); end
        load(6);
        checks++; if (q[0] !== 4'd6 || b[0] !== 1'b0) begin failures++; $display("FAIL start_on_wrap q=%0d borrow=%0d exp q=6 borrow=0", q[0], b[0]); end
        hold = 1;
        load(4);
        hold = 0;
        checks++; if (q[0] !== 4'd4) begin failures++; $display("FAIL start_over_hold got=%0d exp=4", q[0]); end
        tick; tick; tick; tick;
        checks++; if (q[0] !== 4'd0) begin failures++; $display("FAIL simul_zero2 got=%0d exp=0", q[0]); end
        hold = 1;
        tick;
        checks++; if (q[0] !== 4'd0 || b[0] !== 1'b0) begin failures++; $display("FAIL hold_at_zero q=%0d borrow=%0d exp q=0 borrow=0", q[0], b[0]); end
        hold = 0;
        tick;
        checks++; if (q[0] !== 4'd9 || b[0] !== 1'b1) begin failures++; $display("FAIL wrap_after_hold q=%0d borrow=%0d exp q=9 borrow=1", q[0], b[0]); end
    endtask

    task automatic test_random;
        int mq[3] = '{0, 0, 0};
        bit mbz[3] = '{0, 0, 0};
        bit mb[3] = '{0, 0, 0};
        int kk[3] = '{10, 10, 16};
        bit rl[3] = '{1, 0, 1};
        do_reset;
        for (int cyc = 0; cyc < 500; cyc++) begin
            start = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 3) == 0);
            lv    = 4'($urandom_range(0, 15));
            for (int d = 0; d < 3; d++) begin
                int lval = (int'(lv) >= kk[d] || lv == 0) ? kk[d] - 1 : int'(lv);
                mb[d] = 0;
                if (start) begin
                    mq[d] = lval; mbz[d] = 1;
                end else if (mbz[d] && !hold) begin
                    if (mq[d] > 0) mq[d]--;
                    else begin
                        mb[d] = 1;
                        if (rl[d]) mq[d] = kk[d] - 1; else mbz[d] = 0;
                    end
                end
            end
            tick;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (q[d] !== 4'(mq[d]) || b[d] !== mb[d] || bz[d] !== mbz[d]) begin
                    failures++;
                    $display("FAIL random d%0d cyc=%0d got q=%0d b=%0d busy=%0d exp q=%0d b=%0d busy=%0d", d, cyc, q[d], b[d], bz[d], mq[d], mb[d], mbz[d]);
                end
            end
        end
        start = 0; hold = 0;
    endtask

    initial begin
        test_reset;
        test_free_run;
        test_one_shot;
        test_clamp;
        test_hold;
        test_simultaneous;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/down_counter.md
# down_counter

Loadable modulo-k down-counter with a registered borrow pulse; the counting-down counterpart of the team's modulo-k up-counter. It loads a start value, decrements to zero, and emits a one-cycle `borrow` pulse on the wrap. It then either reloads to k-1 (free-running mode) or returns to idle (one-shot mode). Used as a programmable timer and divider wherever a block needs an "N cycles elapsed" event rather than a count-up.

## Interface
- `n`, default 4: counter width in bits.
- `k`, default 10: modulus; legal range 2 ≤ k ≤ 2^n; count values are 0..k-1.
- `RELOAD`, default 1: 1 = free-running (reload k-1 on wrap); 0 = one-shot (stop on wrap).

Ports:
- `Clock`, input, 1: single clock; all state updates on the rising edge.
- `Reset`, input, 1: asynchronous, active-high reset.
- `Start`, input, 1: load `Load_val` and begin counting; sampled each rising edge.
- `Load_val`, input, n: start value.
- `Hold`, input, 1: freeze the count while high in RUN.
- `Q`, output, n: current count, registered.
- `borrow`, output, 1: registered one-cycle pulse on each wrap past zero.
- `busy`, output, 1: high while in RUN.

## Operation
- States: IDLE, RUN. `busy` = (state == RUN), registered.
- Reset, asynchronous, active-high, at any time including mid-count: state IDLE, `Q` = 0, `borrow` = 0, `busy` = 0. Reset dominates every input.
- Load value rule, applied on every accepted `Start`:
  - `Load_val` ≥ k loads k-1 (clamp).
  - `Load_val` = 0 loads k-1.
  - Otherwise loads `Load_val`.
- IDLE:
  - `Start` = 1: load `Q` per the load rule and go to RUN.
  - `Hold` is ignored.
  - `Q` holds its last value; `borrow` = 0.
- RUN, in priority order:
  1. `Start` = 1: reload `Q` per the load rule and stay in RUN. `borrow` = 0, even if `Q` was 0 (restart wins over wrap).
  2. `Hold` = 1: `Q` is unchanged, `borrow` = 0, no state change.
  3. `Q` > 0: `Q` <= `Q` - 1, `borrow` = 0.
  4. `Q` = 0: `borrow` <= 1. If `RELOAD` = 1, `Q` <= k-1 and stay in RUN. If `RELOAD` = 0, `Q` stays 0 and go to IDLE (`busy` falls on the same edge).
- Arithmetic: n-bit unsigned. The decrement never underflows, because 0 is handled by rule 4. The clamp compare uses at least n+1 bits so that k = 2^n works.
- `borrow` is high for exactly one cycle per wrap. Consecutive wraps are spaced k cycles apart in free-running mode with `Hold` low.

## Timing
- Load latency: `Start` sampled at edge t gives `Q` = load value after edge t and `busy` = 1 after edge t.
- Wrap latency: with load value L and `Hold` low, `Q` reaches 0 after edge t+L, and `borrow` is high for the cycle following edge t+L+1.
- Free-running period is k cycles; each `Hold` cycle extends it by 1.
- One-shot mode: `busy` and `borrow` change on the same edge (`busy` 1→0, `borrow` 0→1).
- `Start` arriving on the same edge as a wrap suppresses that `borrow`.
- `Hold` arriving on the same edge that `Q` = 0 delays the `borrow` until the first non-hold edge.
- Reset deassertion: the first rising edge with `Reset` low evaluates IDLE rules normally.
- All outputs are registers; there is no combinational path from any input to any output.

## Test plan
- Reset mid-count (n=4, k=10, `RELOAD`=1): load 7, run 3 cycles (`Q`=4), assert `Reset` between edges -> `Q`=0, `busy`=0, `borrow`=0 immediately, without waiting for a clock edge; the bench then stays IDLE until `Start`.
- Free-running: `Start` with `Load_val`=3 -> `Q` sequence is 3,2,1,0,9,8,…,0,9. `borrow` pulses one cycle after each 0, and the pulses are spaced 10 cycles apart.
- One-shot (`RELOAD`=0): `Start` with `Load_val`=2 -> `Q` sequence 2,1,0. On the next edge `borrow`=1 and `busy`=0, `Q` stays 0, and no further pulses occur.
- Clamp and zero load: `Load_val`=12 -> `Q`=9; `Load_val`=0 -> `Q`=9; `Load_val`=15 with k=16, n=4 -> `Q`=15.
- Hold: load 5, assert `Hold` for 4 cycles at `Q`=3 -> `Q` stays 3 throughout with `borrow`=0, then resumes at 2. The `borrow` pulse arrives 4 cycles later than it would without `Hold`.
- Simultaneous events: `Start` (`Load_val`=6) on the edge where `Q`=0 -> `Q`=6 and `borrow` stays 0. `Hold` and `Start` together -> the reload happens (`Start` has priority).
